// File: rtl/port_mgnt_resp_pkg.sv
// Shared switch management definitions: register map, ID/version constants
// and the response FSM state type.
package port_mgnt_resp_pkg;

    localparam logic [7:0] ADDR_RX_FRAMES  = 8'h00;
    localparam logic [7:0] ADDR_RX_BYTES   = 8'h01;
    localparam logic [7:0] ADDR_RX_CRC_ERR = 8'h02;
    localparam logic [7:0] ADDR_RX_DROP    = 8'h03;
    localparam logic [7:0] ADDR_TX_FRAMES  = 8'h04;
    localparam logic [7:0] ADDR_TX_BYTES   = 8'h05;
    localparam logic [7:0] ADDR_ID         = 8'h06;
    localparam logic [7:0] ADDR_ALL        = 8'hFF;

    localparam logic [7:0] MGNT_ID_CODE = 8'hA5;
    localparam logic [7:0] MGNT_VERSION = 8'h01;

    localparam int unsigned NUM_CNT = 6;

    // Counter index i lives at CNT_ADDR[i].
    localparam logic [7:0] CNT_ADDR [NUM_CNT] = '{
        ADDR_RX_FRAMES, ADDR_RX_BYTES, ADDR_RX_CRC_ERR,
        ADDR_RX_DROP, ADDR_TX_FRAMES, ADDR_TX_BYTES
    };

    typedef enum logic {
        IDLE,
        SEND
    } resp_state_t;

    function automatic logic [31:0] id_word(input logic [7:0] port_id);
        return {MGNT_ID_CODE, MGNT_VERSION, 8'h00, port_id};
    endfunction

endpackage

// File: rtl/port_mgnt_resp_if.sv
// Management request/response link between the register controller (master)
// and a per-port statistics responder (slave).
interface port_mgnt_resp_if;

    logic       sys_req_valid;
    logic       sys_req_wr;
    logic [7:0] sys_req_addr;
    logic       sys_resp_valid;
    logic [7:0] sys_resp_data;

    modport master (
        output sys_req_valid, sys_req_wr, sys_req_addr,
        input  sys_resp_valid, sys_resp_data
    );

    modport slave (
        input  sys_req_valid, sys_req_wr, sys_req_addr,
        output sys_resp_valid, sys_resp_data
    );

endinterface

// File: rtl/mgnt_sat_counter.sv
// Saturating statistics counter: adds a zero-extended amount per increment,
// sticks at all-ones, clear wins over a same-cycle increment.
module mgnt_sat_counter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned AMT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 increment,
    input  logic                 clear,
    input  logic [AMT_WIDTH-1:0] amount,
    output logic [WIDTH-1:0]     value
);

    // One extra bit above the wider operand catches any overflow past WIDTH.
    localparam int unsigned SUM_WIDTH = ((WIDTH > AMT_WIDTH) ? WIDTH : AMT_WIDTH) + 1;

    logic [SUM_WIDTH-1:0] sum;
    logic [WIDTH-1:0]     next_value;

    always_comb begin
        sum = SUM_WIDTH'(value) + SUM_WIDTH'(amount);
        if (sum[SUM_WIDTH-1:WIDTH] != '0)
            next_value = '1;
        else
            next_value = sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (increment)
            value <= next_value;
    end

endmodule

// File: rtl/port_mgnt_resp.sv
// Per-port statistics block: six saturating counters plus an ID register,
// read back as a MSB-first byte stream over the management link.
module port_mgnt_resp
    import port_mgnt_resp_pkg::*;
#(
    parameter int unsigned MGNT_REG_WIDTH = 32,
    parameter logic [7:0]  PORT_ID        = 8'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    port_mgnt_resp_if.slave        sys,
    input  logic                   rx_ok,
    input  logic [15:0]            rx_len,
    input  logic                   rx_crc_err,
    input  logic                   rx_drop,
    input  logic                   tx_ok,
    input  logic [15:0]            tx_len
);

    localparam int unsigned W      = MGNT_REG_WIDTH;
    localparam int unsigned NBYTES = W / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [W+31:0] ID_EXT = {{W{1'b0}}, id_word(PORT_ID)};

    resp_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       snap_q;
    logic [W-1:0]       rd_word;
    logic [W-1:0]       cnt     [NUM_CNT];
    logic [15:0]        cnt_amt [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc;
    logic               req_rd;
    logic               req_clr;
    logic               last_byte;

    always_comb begin
        cnt_inc    = {tx_ok, tx_ok, rx_drop, rx_crc_err, rx_ok, rx_ok};
        cnt_amt[0] = 16'd1;
        cnt_amt[1] = rx_len;
        cnt_amt[2] = 16'd1;
        cnt_amt[3] = 16'd1;
        cnt_amt[4] = 16'd1;
        cnt_amt[5] = tx_len;
    end

    // Requests are only honoured in IDLE; anything arriving during SEND is dropped.
    assign req_rd  = (state_q == IDLE) && sys.sys_req_valid && !sys.sys_req_wr;
    assign req_clr = (state_q == IDLE) && sys.sys_req_valid &&  sys.sys_req_wr;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        mgnt_sat_counter #(
            .WIDTH     (W),
            .AMT_WIDTH (16)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .increment (cnt_inc[i]),
            .clear     (req_clr && (sys.sys_req_addr == CNT_ADDR[i] ||
                                    sys.sys_req_addr == ADDR_ALL)),
            .amount    (cnt_amt[i]),
            .value     (cnt[i])
        );
    end

    always_comb begin
        rd_word = '0;
        case (sys.sys_req_addr)
            ADDR_RX_FRAMES:  rd_word = cnt[0];
            ADDR_RX_BYTES:   rd_word = cnt[1];
            ADDR_RX_CRC_ERR: rd_word = cnt[2];
            ADDR_RX_DROP:    rd_word = cnt[3];
            ADDR_TX_FRAMES:  rd_word = cnt[4];
            ADDR_TX_BYTES:   rd_word = cnt[5];
            ADDR_ID:         rd_word = ID_EXT[W-1:0];
            default:         rd_word = '0;
        endcase
    end

    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_rd)    state_d = SEND;
            SEND:    if (last_byte) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // The snapshot doubles as a shift register so the outgoing byte is always its top byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q <= '0;
            idx_q  <= '0;
        end else if (state_q == IDLE) begin
            if (req_rd) begin
                snap_q <= rd_word;
                idx_q  <= '0;
            end
        end else begin
            snap_q <= snap_q << 8;
            idx_q  <= idx_q + 1'b1;
        end
    end

    always_comb begin
        sys.sys_resp_valid = (state_q == SEND);
        sys.sys_resp_data  = (state_q == SEND) ? snap_q[W-1 -: 8] : '0;
    end

endmodule

// File: tb/tb_port_mgnt_resp.sv
// Self-checking bench for port_mgnt_resp: scoreboarded byte stream on a
// 32-bit instance plus a narrow 8-bit instance for saturation.
module tb_port_mgnt_resp;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] value;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ok, rx_crc_err, rx_drop, tx_ok;
    logic [15:0] rx_len, tx_len;
    logic        tx_ok8;
    logic [15:0] tx_len8;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t        sbq [$];
    exp_t        mon_e;
    vec_t        vecs [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    port_mgnt_resp_if m  ();
    port_mgnt_resp_if m8 ();

    port_mgnt_resp #(
        .MGNT_REG_WIDTH (32),
        .PORT_ID        (8'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sys        (m.slave),
        .rx_ok      (rx_ok),
        .rx_len     (rx_len),
        .rx_crc_err (rx_crc_err),
        .rx_drop    (rx_drop),
        .tx_ok      (tx_ok),
        .tx_len     (tx_len)
    );

    port_mgnt_resp #(
        .MGNT_REG_WIDTH (8),
        .PORT_ID        (8'h07)
    ) dut8 (
        .clk        (clk),
        .rst        (rst),
        .sys        (m8.slave),
        .rx_ok      (1'b0),
        .rx_len     (16'd0),
        .rx_crc_err (1'b0),
        .rx_drop    (1'b0),
        .tx_ok      (tx_ok8),
        .tx_len     (tx_len8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Every output cycle of the 32-bit instance is checked against the scoreboard.
    always @(negedge clk) begin
        if (m.sys_resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_byte", {31'b0, m.sys_resp_valid}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("resp_byte",  {24'b0, m.sys_resp_data}, mon_e.data);
                check("resp_cycle", cyc, mon_e.cyc);
            end
        end else begin
            check("idle_data_zero", {24'b0, m.sys_resp_data}, 32'd0);
        end
    end

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        m.sys_req_valid = 1'b1;
        m.sys_req_wr    = 1'b0;
        m.sys_req_addr  = a;
        @(posedge clk); #1;
        m.sys_req_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            sbq.push_back('{data: {24'b0, exp[31-8*i -: 8]}, cyc: cyc + i});
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sbq.size() != 0 || m.sys_resp_valid) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30) check("drain_timeout", sbq.size(), 32'd0);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp);
        rd(a, exp);
        drain();
    endtask

    task automatic clr(input logic [7:0] a);
        m.sys_req_valid = 1'b1;
        m.sys_req_wr    = 1'b1;
        m.sys_req_addr  = a;
        @(posedge clk); #1;
        m.sys_req_valid = 1'b0;
        m.sys_req_wr    = 1'b0;
    endtask

    task automatic ev(input logic rok, input logic [15:0] rlen, input logic crc,
                      input logic drp, input logic tok, input logic [15:0] tlen,
                      input int unsigned n);
        rx_ok = rok; rx_len = rlen; rx_crc_err = crc; rx_drop = drp;
        tx_ok = tok; tx_len = tlen;
        repeat (n) begin
            @(posedge clk); #1;
        end
        rx_ok = 1'b0; rx_crc_err = 1'b0; rx_drop = 1'b0; tx_ok = 1'b0;
    endtask

    task automatic rd_all(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5);
        rd_chk(8'h00, e0); rd_chk(8'h01, e1); rd_chk(8'h02, e2);
        rd_chk(8'h03, e3); rd_chk(8'h04, e4); rd_chk(8'h05, e5);
    endtask

    task automatic rd8(input logic [7:0] a, input logic [7:0] exp);
        m8.sys_req_valid = 1'b1;
        m8.sys_req_wr    = 1'b0;
        m8.sys_req_addr  = a;
        @(posedge clk); #1;
        m8.sys_req_valid = 1'b0;
        @(negedge clk);
        check("w8_valid", {31'b0, m8.sys_resp_valid}, 32'd1);
        check("w8_data",  {24'b0, m8.sys_resp_data}, {24'b0, exp});
        @(negedge clk);
        check("w8_single_byte", {31'b0, m8.sys_resp_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{8'h00, 32'd3};
        vecs[1] = '{8'h01, 32'h0000_00C0};
        vecs[2] = '{8'h02, 32'd2};
        vecs[3] = '{8'h03, 32'd1};
        vecs[4] = '{8'h04, 32'd4};
        vecs[5] = '{8'h05, 32'h0000_0190};
        vecs[6] = '{8'h06, 32'hA501_0003};
        vecs[7] = '{8'h07, 32'd0};
        vecs[8] = '{8'h40, 32'd0};
        vecs[9] = '{8'hFF, 32'd0};

        rst = 1'b0;
        m.sys_req_valid = 1'b0; m.sys_req_wr = 1'b0; m.sys_req_addr = 8'h00;
        m8.sys_req_valid = 1'b0; m8.sys_req_wr = 1'b0; m8.sys_req_addr = 8'h00;
        rx_ok = 1'b0; rx_len = 16'd0; rx_crc_err = 1'b0; rx_drop = 1'b0;
        tx_ok = 1'b0; tx_len = 16'd0; tx_ok8 = 1'b0; tx_len8 = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, m.sys_resp_valid}, 32'd0);
        check("rst_data",  {24'b0, m.sys_resp_data}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rd_all(0, 0, 0, 0, 0, 0);

        // Known traffic, then the register map via the vector table.
        ev(1'b1, 16'd64, 1'b0, 1'b0, 1'b0, 16'd0, 3);
        ev(1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0, 2);
        ev(1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 16'd0, 1);
        ev(1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 16'd100, 4);
        for (int i = 0; i < 10; i++) rd_chk(vecs[i].addr, vecs[i].value);

        // Clears of the ID register and unmapped addresses change nothing.
        clr(8'h06); clr(8'h40); clr(8'h07);
        for (int i = 0; i < 7; i++) rd_chk(vecs[i].addr, vecs[i].value);

        // Snapshot: an error pulse during SEND does not alter the bytes in flight.
        rd(8'h02, 32'd2);
        ev(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1);
        drain();
        rd_chk(8'h02, 32'd3);

        // Requests during SEND are ignored entirely.
        rd(8'h00, 32'd3);
        m.sys_req_valid = 1'b1; m.sys_req_wr = 1'b0; m.sys_req_addr = 8'h05;
        @(posedge clk); #1;
        m.sys_req_wr = 1'b1; m.sys_req_addr = 8'h00;
        @(posedge clk); #1;
        m.sys_req_valid = 1'b0; m.sys_req_wr = 1'b0;
        drain();
        rd_chk(8'h00, 32'd3);

        // Clear of one counter beats a same-cycle event; the sibling still counts.
        m.sys_req_valid = 1'b1; m.sys_req_wr = 1'b1; m.sys_req_addr = 8'h00;
        ev(1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 16'd0, 1);
        m.sys_req_valid = 1'b0; m.sys_req_wr = 1'b0;
        rd_all(0, 32'h0000_00CA, 3, 1, 4, 32'h0000_0190);

        // Clear-all with concurrent events on several counters.
        m.sys_req_valid = 1'b1; m.sys_req_wr = 1'b1; m.sys_req_addr = 8'hFF;
        ev(1'b1, 16'd10, 1'b1, 1'b1, 1'b1, 16'd20, 1);
        m.sys_req_valid = 1'b0; m.sys_req_wr = 1'b0;
        rd_all(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a response.
        ev(1'b1, 16'd64, 1'b0, 1'b0, 1'b0, 16'd0, 1);
        rd(8'h01, 32'h0000_0040);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, m.sys_resp_valid}, 32'd0);
        check("rst_mid_data",  {24'b0, m.sys_resp_data}, 32'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rd_all(0, 0, 0, 0, 0, 0);
        rd_chk(8'h06, 32'hA501_0003);

        // Narrow instance: drive tx counters to one below saturation, then past it.
        tx_ok8 = 1'b1; tx_len8 = 16'd200;
        repeat (254) @(posedge clk);
        #1;
        tx_ok8 = 1'b0;
        rd8(8'h04, 8'hFE);
        rd8(8'h05, 8'hFF);
        tx_ok8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tx_ok8 = 1'b0;
        rd8(8'h04, 8'hFF);
        rd8(8'h06, 8'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
